// File: rtl/pulse_period_monitor.sv
// Pulse period statistics downstream of the correlator: moving average, min/max/last
// period, latest phase, missing-pulse timeout, one record per pulse on valid/ready.
module pulse_period_monitor #(
   parameter int PERIOD_W   = 21,
   parameter int PHASE_W    = 10,
   parameter int AVG_LOG2   = 3,
   parameter int CNT_W      = 16,
   parameter int TIMEOUT_US = 2000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                time_point,
   input  logic [PERIOD_W-1:0] period,
   input  logic                phase_mark,
   input  logic [PHASE_W-1:0]  phase_time,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [PERIOD_W-1:0] last_period,
   output logic [PERIOD_W-1:0] avg_period,
   output logic [PERIOD_W-1:0] min_period,
   output logic [PERIOD_W-1:0] max_period,
   output logic [PHASE_W-1:0]  last_phase,
   output logic [CNT_W-1:0]    pulse_count,
   output logic                locked,
   output logic                timeout,
   output logic                overrun
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = PERIOD_W + AVG_LOG2;
   localparam logic [AVG_LOG2:0]   FILL_FULL = (AVG_LOG2+1)'(DEPTH);
   localparam logic [PERIOD_W-1:0] GAP_LIMIT = PERIOD_W'(TIMEOUT_US);
   localparam logic [PERIOD_W-1:0] GAP_LAST  = PERIOD_W'(TIMEOUT_US - 1);

   logic [PERIOD_W-1:0] win_q [DEPTH];
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [AVG_LOG2:0]   fill_q, fill_d;
   logic [AVG_LOG2-1:0] wrPtr_q, wrPtr_d;
   logic [PERIOD_W-1:0] gap_q, gap_d;
   logic                skipNext_q, skipNext_d;
   logic                pend_q, pend_d;
   logic [PERIOD_W-1:0] statMin_q, statMin_d, statMax_q, statMax_d, statLast_q, statLast_d;
   logic [CNT_W-1:0]    statCount_q, statCount_d;
   logic                outValid_q, outValid_d;
   logic [PERIOD_W-1:0] lastOut_q, lastOut_d, avgOut_q, avgOut_d;
   logic [PERIOD_W-1:0] minOut_q, minOut_d, maxOut_q, maxOut_d;
   logic [CNT_W-1:0]    countOut_q, countOut_d;
   logic                locked_q, locked_d, timeout_q, timeout_d, overrun_q, overrun_d;
   logic [PHASE_W-1:0]  lastPhase_q, lastPhase_d;
   logic                markPrev_q;

   logic                accept, gapHit, windowFull, xfer, phaseFall;
   logic [PERIOD_W-1:0] oldEntry;

   assign accept     = time_point && (period != '0) && !skipNext_q;
   assign gapHit     = !time_point && (gap_q == GAP_LAST);
   assign windowFull = (fill_q == FILL_FULL);
   assign xfer       = outValid_q && out_ready;
   assign phaseFall  = markPrev_q && !phase_mark;
   // Stale RAM entries after a timeout must not be subtracted while refilling.
   assign oldEntry   = windowFull ? win_q[wrPtr_q] : '0;

   always_comb begin
      sum_d       = sum_q;
      fill_d      = fill_q;
      wrPtr_d     = wrPtr_q;
      gap_d       = gap_q;
      skipNext_d  = skipNext_q;
      pend_d      = 1'b0;
      statMin_d   = statMin_q;
      statMax_d   = statMax_q;
      statLast_d  = statLast_q;
      statCount_d = statCount_q;
      outValid_d  = outValid_q;
      lastOut_d   = lastOut_q;
      avgOut_d    = avgOut_q;
      minOut_d    = minOut_q;
      maxOut_d    = maxOut_q;
      countOut_d  = countOut_q;
      locked_d    = locked_q;
      timeout_d   = timeout_q;
      overrun_d   = overrun_q;
      lastPhase_d = phaseFall ? phase_time : lastPhase_q;

      if (time_point) begin
         gap_d     = '0;
         timeout_d = 1'b0;
         if (skipNext_q) skipNext_d = 1'b0;
      end else if (gap_q != GAP_LIMIT) begin
         gap_d = gap_q + 1'b1;
      end

      if (accept) begin
         sum_d       = sum_q + SUM_W'(period) - SUM_W'(oldEntry);
         wrPtr_d     = wrPtr_q + 1'b1;
         fill_d      = windowFull ? fill_q : fill_q + 1'b1;
         statMin_d   = (period < statMin_q) ? period : statMin_q;
         statMax_d   = (period > statMax_q) ? period : statMax_q;
         statLast_d  = period;
         statCount_d = (statCount_q == '1) ? statCount_q : statCount_q + 1'b1;
         pend_d      = 1'b1;
      end

      // A landing record is presented whether or not the previous one was taken.
      if (pend_q) begin
         outValid_d = 1'b1;
         if (xfer)            overrun_d = 1'b0;
         else if (outValid_q) overrun_d = 1'b1;
         lastOut_d  = statLast_q;
         minOut_d   = statMin_q;
         maxOut_d   = statMax_q;
         countOut_d = statCount_q;
         avgOut_d   = windowFull ? sum_q[SUM_W-1:AVG_LOG2] : '0;
         locked_d   = windowFull;
      end else if (xfer) begin
         outValid_d = 1'b0;
         overrun_d  = 1'b0;
      end

      if (gapHit) begin
         timeout_d  = 1'b1;
         skipNext_d = 1'b1;
         sum_d      = '0;
         fill_d     = '0;
         wrPtr_d    = '0;
         statMin_d  = '1;
         statMax_d  = '0;
         minOut_d   = '1;
         maxOut_d   = '0;
         avgOut_d   = '0;
         locked_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      end else if (accept) begin
         win_q[wrPtr_q] <= period;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q       <= '0;
         fill_q      <= '0;
         wrPtr_q     <= '0;
         gap_q       <= '0;
         skipNext_q  <= 1'b0;
         pend_q      <= 1'b0;
         statMin_q   <= '1;
         statMax_q   <= '0;
         statLast_q  <= '0;
         statCount_q <= '0;
         outValid_q  <= 1'b0;
         lastOut_q   <= '0;
         avgOut_q    <= '0;
         minOut_q    <= '1;
         maxOut_q    <= '0;
         countOut_q  <= '0;
         locked_q    <= 1'b0;
         timeout_q   <= 1'b0;
         overrun_q   <= 1'b0;
         lastPhase_q <= '0;
         markPrev_q  <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         fill_q      <= fill_d;
         wrPtr_q     <= wrPtr_d;
         gap_q       <= gap_d;
         skipNext_q  <= skipNext_d;
         pend_q      <= pend_d;
         statMin_q   <= statMin_d;
         statMax_q   <= statMax_d;
         statLast_q  <= statLast_d;
         statCount_q <= statCount_d;
         outValid_q  <= outValid_d;
         lastOut_q   <= lastOut_d;
         avgOut_q    <= avgOut_d;
         minOut_q    <= minOut_d;
         maxOut_q    <= maxOut_d;
         countOut_q  <= countOut_d;
         locked_q    <= locked_d;
         timeout_q   <= timeout_d;
         overrun_q   <= overrun_d;
         lastPhase_q <= lastPhase_d;
         markPrev_q  <= phase_mark;
      end
   end

   assign out_valid   = outValid_q;
   assign last_period = lastOut_q;
   assign avg_period  = avgOut_q;
   assign min_period  = minOut_q;
   assign max_period  = maxOut_q;
   assign last_phase  = lastPhase_q;
   assign pulse_count = countOut_q;
   assign locked      = locked_q;
   assign timeout     = timeout_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Self-checking bench for pulse_period_monitor: constant vector table, hand-written
// handshake/timeout/phase/reset sequences, and randomized pulses against a queue model.
module tb_pulse_period_monitor;

   localparam int PERIOD_W = 21;
   localparam int PHASE_W  = 10;
   localparam int AVG_LOG2 = 3;
   localparam int CNT_W    = 6;
   localparam int TO       = 1500;
   localparam int DEPTH    = 8;
   localparam longint ALLONES = (64'd1 << PERIOD_W) - 1;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                time_point = 1'b0;
   logic [PERIOD_W-1:0] period = '0;
   logic                phase_mark = 1'b0;
   logic [PHASE_W-1:0]  phase_time = '0;
   logic                out_ready = 1'b1;
   logic                out_valid;
   logic [PERIOD_W-1:0] last_period, avg_period, min_period, max_period;
   logic [PHASE_W-1:0]  last_phase;
   logic [CNT_W-1:0]    pulse_count;
   logic                locked, timeout, overrun;

   pulse_period_monitor #(
      .PERIOD_W(PERIOD_W), .PHASE_W(PHASE_W), .AVG_LOG2(AVG_LOG2),
      .CNT_W(CNT_W), .TIMEOUT_US(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .time_point(time_point), .period(period),
      .phase_mark(phase_mark), .phase_time(phase_time), .out_ready(out_ready),
      .out_valid(out_valid), .last_period(last_period), .avg_period(avg_period),
      .min_period(min_period), .max_period(max_period), .last_phase(last_phase),
      .pulse_count(pulse_count), .locked(locked), .timeout(timeout), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int errCount = 0;
   int checkCount = 0;

   // Reference model state: window as a queue of accepted periods.
   int unsigned winQ[$];
   longint mMin, mMax;
   int     mCount, sinceTp, mPhase;
   bit     mSkip, mTimeout, mLand, mValid, mOver, pmPrev;
   longint eLast, eAvg, eMin, eMax, eCount;
   bit     eLocked;
   longint pLast, pAvg, pMin, pMax, pCount;
   bit     pLocked;
   bit     phaseRandom = 1'b0;
   bit     readyRandom = 1'b0;

   typedef struct {
      int unsigned per;
      int unsigned expAvg;
      bit          expLocked;
      int unsigned expMin;
      int unsigned expMax;
      int unsigned expCount;
   } vec_t;
   vec_t vecs[24];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic resetModel();
      winQ.delete();
      mMin = ALLONES; mMax = 0; mCount = 0; sinceTp = 0; mPhase = 0;
      mSkip = 0; mTimeout = 0; mLand = 0; mValid = 0; mOver = 0; pmPrev = 0;
      eLast = 0; eAvg = 0; eMin = ALLONES; eMax = 0; eCount = 0; eLocked = 0;
   endtask

   task automatic modelAccept(input int unsigned p);
      longint s;
      winQ.push_back(p);
      if (winQ.size() > DEPTH) void'(winQ.pop_front());
      s = 0;
      foreach (winQ[i]) s += winQ[i];
      if (p < mMin) mMin = p;
      if (p > mMax) mMax = p;
      if (mCount < CNT_MAX) mCount++;
      pLast = p; pMin = mMin; pMax = mMax; pCount = mCount;
      pLocked = (winQ.size() == DEPTH);
      pAvg = pLocked ? s / DEPTH : 0;
   endtask

   // Drive one clock edge's worth of inputs, advance the model across it, land on the next negedge.
   task automatic stepCycle();
      bit xfer;
      if (phaseRandom) begin
         if ($urandom_range(0, 5) == 0) phase_mark = ~phase_mark;
         phase_time = PHASE_W'($urandom_range(0, (1 << PHASE_W) - 1));
      end
      if (readyRandom) out_ready = ($urandom_range(0, 3) != 0);
      if (pmPrev && !phase_mark) mPhase = phase_time;
      pmPrev = phase_mark;
      xfer = mValid && out_ready;
      if (mLand) begin
         if (xfer) mOver = 0;
         else if (mValid) mOver = 1;
         mValid = 1;
         eLast = pLast; eAvg = pAvg; eMin = pMin; eMax = pMax; eCount = pCount; eLocked = pLocked;
      end else if (xfer) begin
         mValid = 0;
         mOver = 0;
      end
      mLand = 0;
      if (time_point) begin
         sinceTp = 0;
         mTimeout = 0;
      end else if (sinceTp < TO) begin
         sinceTp++;
         if (sinceTp == TO) begin
            mTimeout = 1; mSkip = 1; winQ.delete();
            mMin = ALLONES; mMax = 0;
            eAvg = 0; eLocked = 0; eMin = ALLONES; eMax = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   task automatic checkIdleState();
      checkOutput("idle_timeout", timeout, mTimeout);
      checkOutput("idle_locked", locked, eLocked);
      checkOutput("idle_avg", avg_period, eAvg);
      checkOutput("idle_min", min_period, eMin);
      checkOutput("idle_max", max_period, eMax);
      checkOutput("idle_phase", last_phase, mPhase);
   endtask

   // One time_point strobe; returns at the negedge after T+2 with the record checked.
   task automatic applyStimulus(input int unsigned p);
      bit acc;
      acc = (p != 0) && !mSkip;
      if (mSkip) mSkip = 0;
      if (acc) modelAccept(p);
      time_point = 1'b1;
      period = PERIOD_W'(p);
      stepCycle();
      time_point = 1'b0;
      period = PERIOD_W'($urandom);
      checkOutput("valid_t1", out_valid, mValid);
      mLand = acc;
      stepCycle();
      checkOutput("valid_t2", out_valid, mValid);
      checkOutput("overrun", overrun, mOver);
      checkOutput("timeout", timeout, mTimeout);
      checkOutput("last_phase", last_phase, mPhase);
      if (acc) begin
         checkOutput("last_period", last_period, eLast);
         checkOutput("avg_period", avg_period, eAvg);
         checkOutput("min_period", min_period, eMin);
         checkOutput("max_period", max_period, eMax);
         checkOutput("pulse_count", pulse_count, eCount);
         checkOutput("locked", locked, eLocked);
      end
   endtask

   initial begin
      resetModel();
      for (int i = 0; i < 24; i++) begin
         if (i < 8) begin
            vecs[i] = '{1000, (i == 7) ? 1000 : 0, i == 7, 1000, 1000, i + 1};
         end else begin
            int k;
            k = i - 7;
            vecs[i].per       = (k % 2 == 1) ? 900 : 1100;
            vecs[i].expAvg    = (k < 8 && k % 2 == 1) ? 987 : 1000;
            vecs[i].expLocked = 1'b1;
            vecs[i].expMin    = 900;
            vecs[i].expMax    = (k >= 2) ? 1100 : 1000;
            vecs[i].expCount  = i + 1;
         end
      end

      @(negedge clk);
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_min", min_period, ALLONES);
      checkOutput("rst_count", pulse_count, 0);
      checkOutput("rst_locked", locked, 0);
      rst_n = 1'b1;

      // Fill and wrap the window at a 1000-cycle pulse spacing.
      for (int i = 0; i < 24; i++) begin
         idle(998);
         applyStimulus(vecs[i].per);
         checkOutput("vec_valid", out_valid, 1);
         checkOutput("vec_last", last_period, vecs[i].per);
         checkOutput("vec_avg", avg_period, vecs[i].expAvg);
         checkOutput("vec_locked", locked, vecs[i].expLocked);
         checkOutput("vec_min", min_period, vecs[i].expMin);
         checkOutput("vec_max", max_period, vecs[i].expMax);
         checkOutput("vec_count", pulse_count, vecs[i].expCount);
      end

      // Back-pressure across two records.
      idle(20);
      out_ready = 1'b0;
      applyStimulus(1000);
      idle(50);
      checkOutput("hs_hold_valid", out_valid, 1);
      checkOutput("hs_hold_last", last_period, 1000);
      checkOutput("hs_hold_overrun", overrun, 0);
      applyStimulus(1200);
      checkOutput("hs_new_last", last_period, 1200);
      checkOutput("hs_overrun_set", overrun, 1);
      out_ready = 1'b1;
      stepCycle();
      out_ready = 1'b0;
      checkOutput("hs_valid_drop", out_valid, 0);
      checkOutput("hs_overrun_clr", overrun, 0);
      out_ready = 1'b1;

      // Missing pulses after lock.
      idle(TO + 5);
      checkOutput("to_timeout", timeout, 1);
      checkOutput("to_locked", locked, 0);
      checkOutput("to_avg", avg_period, 0);
      checkIdleState();
      applyStimulus(2000999);
      checkOutput("to_skip_valid", out_valid, 0);
      checkOutput("to_cleared", timeout, 0);
      idle(100);
      applyStimulus(1000);
      checkOutput("to_restart_min", min_period, 1000);
      checkOutput("to_restart_max", max_period, 1000);

      // Phase falling edge coincident with a time_point, then a period=0 strobe.
      idle(50);
      phase_mark = 1'b1;
      idle(600);
      phase_mark = 1'b0;
      phase_time = PHASE_W'(600);
      applyStimulus(1500);
      checkOutput("ph_last_phase", last_phase, 600);
      checkOutput("ph_valid", out_valid, 1);
      idle(1000);
      applyStimulus(0);
      checkOutput("zero_no_record", out_valid, 0);
      idle(1200);
      checkOutput("zero_gap_cleared", timeout, 0);

      // Asynchronous reset with a record pending and five entries in the window.
      for (int i = 0; i < 3; i++) begin
         idle(20);
         applyStimulus(700);
      end
      checkOutput("arst_pre_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_valid", out_valid, 0);
      checkOutput("arst_last", last_period, 0);
      checkOutput("arst_avg", avg_period, 0);
      checkOutput("arst_min", min_period, ALLONES);
      checkOutput("arst_max", max_period, 0);
      checkOutput("arst_count", pulse_count, 0);
      checkOutput("arst_overrun", overrun, 0);
      @(negedge clk);
      rst_n = 1'b1;
      resetModel();
      for (int i = 0; i < 8; i++) begin
         idle(30);
         applyStimulus(800);
         checkOutput("arst_relock", locked, i == 7);
      end

      // Randomized pulses, gaps, back-pressure and phase activity.
      phaseRandom = 1'b1;
      readyRandom = 1'b1;
      for (int n = 0; n < 80; n++) begin
         int r, g;
         int unsigned p;
         r = $urandom_range(0, 24);
         case (r)
            0:       g = TO - 1;
            1:       g = TO;
            2:       g = TO + 1;
            default: g = $urandom_range(3, 40);
         endcase
         if ($urandom_range(0, 9) == 0) p = 0;
         else if ($urandom_range(0, 1) == 0) p = $urandom_range(1, 2000);
         else p = $urandom_range(1, (1 << PERIOD_W) - 1);
         idle(g - 2);
         checkIdleState();
         applyStimulus(p);
      end
      checkOutput("sat_count", pulse_count, mCount);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
